// File: rtl/fifo_pkg.sv
// Shared helpers and defaults for the synchronous FIFO family (sync_fifo_param, fifo_ram).
// Consumers honour the SYNC_FIFO_FWFT_EN macro for first-word-fall-through reads.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port DATA_W x DEPTH storage: synchronous write, registered read port,
// or an asynchronous read port when SYNC_FIFO_FWFT_EN is defined.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = addr_w(DEPTH)
) (
    input  logic              i_clk,
`ifndef SYNC_FIFO_FWFT_EN
    input  logic              i_rst,
    input  logic              i_re,
`endif
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is deliberately never reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign o_rdata = r_mem[i_raddr];
`else
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output instead of registered reads.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = addr_w(DEPTH),
    localparam int CW      = addr_w(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [CW-1:0]     count,
    output logic              overflow,
    output logic              underflow
);

    generate
        if (!is_pow2(DEPTH)) begin : g_depth_chk
            $error("sync_fifo_param: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [DATA_W-1:0] w_ram_rdata;

    assign empty        = (r_count == '0);
    assign full         = (r_count == CW'(DEPTH));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A write on full only proceeds when a read frees the slot in the same cycle.
    assign w_rd_acc = rd_en && !empty;
    assign w_wr_acc = wr_en && (!full || w_rd_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_overflow  <= wr_en && !w_wr_acc;
            r_underflow <= rd_en && !w_rd_acc;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .i_clk   (clk),
`ifndef SYNC_FIFO_FWFT_EN
        .i_rst   (rst),
        .i_re    (w_rd_acc),
`endif
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = empty ? '0 : w_ram_rdata;
`else
    assign data_out = w_ram_rdata;
`endif

endmodule
